// File: rtl/regfile_mp_sb_pkg.sv
// ----------------------------------------------------------------------------
// regfile_mp_sb_pkg
// Shared CPU definitions: default datapath and register-index widths and the
// index of the hardwired-zero register. The ALU and control blocks use the
// same defaults.
// ----------------------------------------------------------------------------
package regfile_mp_sb_pkg;

    localparam int DATA_W_DEF = 32;   // register width in bits
    localparam int ADDR_W_DEF = 5;    // register index width
    localparam int REG_ZERO   = 0;    // hardwired-zero register index

endpackage : regfile_mp_sb_pkg

// File: rtl/regfile_mp_sb_if.sv
// ----------------------------------------------------------------------------
// regfile_mp_sb_if
// Bus between the pipeline (decode/issue and writeback) and the register file.
//   read   : ra0/ra1 -> rd0/rd1 data, rbusy0/rbusy1 pending-write flags
//   write  : we0/wa0/wd0/wclr0 (ALU wb), we1/wa1/wd1/wclr1 (memory wb)
//   issue  : iss_en/iss_rd marks a destination register busy
//   debug  : busy_vec, the full scoreboard
// master = pipeline side, slave = register file.
// ----------------------------------------------------------------------------
interface regfile_mp_sb_if
    import regfile_mp_sb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [ADDR_W-1:0] ra0;
    logic [ADDR_W-1:0] ra1;
    logic [DATA_W-1:0] rd0;
    logic [DATA_W-1:0] rd1;
    logic              rbusy0;
    logic              rbusy1;
    logic              we0;
    logic [ADDR_W-1:0] wa0;
    logic [DATA_W-1:0] wd0;
    logic              wclr0;
    logic              we1;
    logic [ADDR_W-1:0] wa1;
    logic [DATA_W-1:0] wd1;
    logic              wclr1;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_rd;
    logic [DEPTH-1:0]  busy_vec;

    modport master (
        output ra0, ra1, we0, wa0, wd0, wclr0, we1, wa1, wd1, wclr1, iss_en, iss_rd,
        input  rd0, rd1, rbusy0, rbusy1, busy_vec
    );

    modport slave (
        input  ra0, ra1, we0, wa0, wd0, wclr0, we1, wa1, wd1, wclr1, iss_en, iss_rd,
        output rd0, rd1, rbusy0, rbusy1, busy_vec
    );

endinterface : regfile_mp_sb_if

// File: rtl/regfile_mp_sb_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_mp_sb_scoreboard
// One busy bit per register. An issuing instruction sets its destination's
// bit; a writeback carrying wclr clears it. Set wins over clear because the
// newly issued instruction now owns the register. Register 0 is never busy.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   we*_i, wa*_i, wclr*_i    writeback ports (clear only when we & wclr)
//   iss_en_i, iss_rd_i       issue (set, visible from the next cycle)
//   ra0_i, ra1_i             read indices for rbusy*_o
//   busy_vec_o               registered busy bits
//   rbusy0_o, rbusy1_o       busy bit masked by a same-cycle retiring write
// ----------------------------------------------------------------------------
module regfile_mp_sb_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we0_i,
    input  logic [ADDR_W-1:0]    wa0_i,
    input  logic                 wclr0_i,
    input  logic                 we1_i,
    input  logic [ADDR_W-1:0]    wa1_i,
    input  logic                 wclr1_i,
    input  logic                 iss_en_i,
    input  logic [ADDR_W-1:0]    iss_rd_i,
    input  logic [ADDR_W-1:0]    ra0_i,
    input  logic [ADDR_W-1:0]    ra1_i,
    output logic [2**ADDR_W-1:0] busy_vec_o,
    output logic                 rbusy0_o,
    output logic                 rbusy1_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] clr_vec, set_vec;

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (we0_i && wclr0_i) clr_vec[wa0_i] = 1'b1;
        if (we1_i && wclr1_i) clr_vec[wa1_i] = 1'b1;
        if (iss_en_i)         set_vec[iss_rd_i] = 1'b1;
        set_vec[0] = 1'b0;    // issues to register 0 are dropped
        busy_d = (busy_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    // A register retiring this cycle already has its data on the bypass path.
    assign rbusy0_o   = busy_q[ra0_i] & ~clr_vec[ra0_i];
    assign rbusy1_o   = busy_q[ra1_i] & ~clr_vec[ra1_i];
    assign busy_vec_o = busy_q;

endmodule : regfile_mp_sb_scoreboard

// File: rtl/regfile_mp_sb.sv
// ----------------------------------------------------------------------------
// regfile_mp_sb
// Pipelined-CPU register file: two combinational read ports with write-first
// bypass, two synchronous write ports (port 1 wins on a collision), a
// hardwired-zero register 0 and a busy scoreboard for the hazard unit.
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset (registers -> RESET_VAL, busy -> 0)
//   bus   regfile_mp_sb_if slave modport (read, write, issue, busy_vec)
// ----------------------------------------------------------------------------
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int                 DATA_W    = DATA_W_DEF,
    parameter int                 ADDR_W    = ADDR_W_DEF,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic           clk,
    input  logic           rst,
    regfile_mp_sb_if.slave bus
);
    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    // Port 1 is applied last so it wins when both ports hit the same index.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        regs_d = regs_q;
        if (bus.we0 && bus.wa0 != ZERO_IDX) regs_d[bus.wa0] = bus.wd0;
        if (bus.we1 && bus.wa1 != ZERO_IDX) regs_d[bus.wa1] = bus.wd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this array is small flop storage, so every entry is reset; a RAM macro could not be.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == REG_ZERO) ? '0 : RESET_VAL;
            end
        end else begin
            // NOTE: sequential state uses <= so all flops sample pre-edge values.
            regs_q <= regs_d;
        end
    end

    // Write-first read: a same-cycle write to the index is forwarded,
    // port 1 taking priority; index 0 always reads as zero.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] stored,
        input logic              we0,
        input logic [ADDR_W-1:0] wa0,
        input logic [DATA_W-1:0] wd0,
        input logic              we1,
        input logic [ADDR_W-1:0] wa1,
        input logic [DATA_W-1:0] wd1
    );
        if (ra == ZERO_IDX)          return '0;
        else if (we1 && wa1 == ra)   return wd1;
        else if (we0 && wa0 == ra)   return wd0;
        else                         return stored;
    endfunction

    assign bus.rd0 = read_port(bus.ra0, regs_q[bus.ra0], bus.we0, bus.wa0, bus.wd0,
                               bus.we1, bus.wa1, bus.wd1);
    assign bus.rd1 = read_port(bus.ra1, regs_q[bus.ra1], bus.we0, bus.wa0, bus.wd0,
                               bus.we1, bus.wa1, bus.wd1);

    regfile_mp_sb_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .we0_i      (bus.we0),
        .wa0_i      (bus.wa0),
        .wclr0_i    (bus.wclr0),
        .we1_i      (bus.we1),
        .wa1_i      (bus.wa1),
        .wclr1_i    (bus.wclr1),
        .iss_en_i   (bus.iss_en),
        .iss_rd_i   (bus.iss_rd),
        .ra0_i      (bus.ra0),
        .ra1_i      (bus.ra1),
        .busy_vec_o (bus.busy_vec),
        .rbusy0_o   (bus.rbusy0),
        .rbusy1_o   (bus.rbusy1)
    );

endmodule : regfile_mp_sb

// File: tb/tb_regfile_mp_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_mp_sb
// Directed vector table, a reset-during-operation sequence, then randomized
// traffic compared against a behavioural model of the register file.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ----------------------------------------------------------------------------
module tb_regfile_mp_sb;

    localparam int          DATA_W    = 32;
    localparam int          ADDR_W    = 5;
    localparam int          DEPTH     = 2 ** ADDR_W;
    localparam logic [31:0] RESET_VAL = 32'h1;

    logic clk;
    logic rst;

    regfile_mp_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_mp_sb #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [DEPTH];
    logic [31:0] m_busy;

    // Content a register will hold after this edge; with write-first
    // semantics this is also what a read sees during the cycle.
    function automatic logic [31:0] m_after(input int idx);
        logic [31:0] v;
        if (idx == 0) return 32'h0;
        v = m_regs[idx];
        if (bus.we0 && int'(bus.wa0) == idx) v = bus.wd0;
        if (bus.we1 && int'(bus.wa1) == idx) v = bus.wd1;   // later write wins
        return v;
    endfunction

    function automatic bit m_retiring(input int idx);
        return (bus.we0 && bus.wclr0 && int'(bus.wa0) == idx) ||
               (bus.we1 && bus.wclr1 && int'(bus.wa1) == idx);
    endfunction

    task automatic model_update();
        logic [31:0] nregs [DEPTH];
        logic [31:0] nbusy;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) nregs[i] = (i == 0) ? 32'h0 : RESET_VAL;
            nbusy = '0;
        end else begin
            nbusy = m_busy;
            for (int i = 0; i < DEPTH; i++) begin
                nregs[i] = m_after(i);
                if (m_retiring(i)) nbusy[i] = 1'b0;
                if (i != 0 && bus.iss_en && int'(bus.iss_rd) == i) nbusy[i] = 1'b1;
            end
        end
        m_regs = nregs;
        m_busy = nbusy;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.we0 = 0; bus.wa0 = '0; bus.wd0 = '0; bus.wclr0 = 0;
        bus.we1 = 0; bus.wa1 = '0; bus.wd1 = '0; bus.wclr1 = 0;
        bus.iss_en = 0; bus.iss_rd = '0;
        bus.ra0 = '0; bus.ra1 = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we0;  logic [4:0] wa0; logic [31:0] wd0; logic wclr0;
        logic        we1;  logic [4:0] wa1; logic [31:0] wd1; logic wclr1;
        logic        iss;  logic [4:0] iss_rd;
        logic [4:0]  ra0;  logic [4:0] ra1;
        logic [31:0] e_rd0; logic [31:0] e_rd1;
        logic        e_rb0; logic e_rb1;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(
        input logic we0, input logic [4:0] wa0, input logic [31:0] wd0, input logic wclr0,
        input logic we1, input logic [4:0] wa1, input logic [31:0] wd1, input logic wclr1,
        input logic iss, input logic [4:0] iss_rd, input logic [4:0] ra0, input logic [4:0] ra1,
        input logic [31:0] e_rd0, input logic [31:0] e_rd1, input logic e_rb0, input logic e_rb1,
        input logic [31:0] e_busy);
        vec_t v;
        v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0; v.wclr0 = wclr0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1; v.wclr1 = wclr1;
        v.iss = iss; v.iss_rd = iss_rd; v.ra0 = ra0; v.ra1 = ra1;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_rb0 = e_rb0; v.e_rb1 = e_rb1; v.e_busy = e_busy;
        return v;
    endfunction

    initial begin
        //            we0 wa0 wd0           clr0 we1 wa1 wd1    clr1 iss rd  ra0 ra1  e_rd0         e_rd1         rb0 rb1 busy
        vecs[0]  = mk(0, 0, 32'h0,          0,   0, 0, 32'h0,  0,   0, 0,  5,  0,  32'h1,        32'h0,        0, 0, 32'h0);
        vecs[1]  = mk(1, 3, 32'hDEADBEEF,   0,   0, 0, 32'h0,  0,   0, 0,  3,  3,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'h0);
        vecs[2]  = mk(0, 0, 32'h0,          0,   0, 0, 32'h0,  0,   0, 0,  3,  2,  32'hDEADBEEF, 32'h1,        0, 0, 32'h0);
        vecs[3]  = mk(1, 7, 32'h11,         0,   1, 7, 32'h22, 0,   0, 0,  7,  7,  32'h22,       32'h22,       0, 0, 32'h0);
        vecs[4]  = mk(1, 0, 32'hFFFFFFFF,   0,   0, 0, 32'h0,  0,   0, 0,  0,  7,  32'h0,        32'h22,       0, 0, 32'h0);
        vecs[5]  = mk(0, 0, 32'h0,          0,   0, 0, 32'h0,  0,   1, 4,  4,  4,  32'h1,        32'h1,        0, 0, 32'h0);
        vecs[6]  = mk(0, 0, 32'h0,          0,   0, 0, 32'h0,  0,   0, 0,  4,  0,  32'h1,        32'h0,        1, 0, 32'h10);
        vecs[7]  = mk(0, 0, 32'h0,          0,   1, 4, 32'h55, 1,   0, 0,  4,  4,  32'h55,       32'h55,       0, 0, 32'h10);
        vecs[8]  = mk(0, 0, 32'h0,          0,   0, 0, 32'h0,  0,   0, 0,  4,  0,  32'h55,       32'h0,        0, 0, 32'h0);
        vecs[9]  = mk(1, 9, 32'h99,         1,   0, 0, 32'h0,  0,   1, 9,  9,  9,  32'h99,       32'h99,       0, 0, 32'h0);
        vecs[10] = mk(0, 0, 32'h0,          0,   0, 0, 32'h0,  0,   0, 0,  9,  0,  32'h99,       32'h0,        1, 0, 32'h200);
        vecs[11] = mk(0, 0, 32'h0,          0,   0, 0, 32'h0,  0,   1, 0,  0,  9,  32'h0,        32'h99,       0, 1, 32'h200);
        vecs[12] = mk(0, 0, 32'h0,          0,   0, 0, 32'h0,  0,   0, 0,  0,  9,  32'h0,        32'h99,       0, 1, 32'h200);
        vecs[13] = mk(0, 9, 32'h0,          1,   0, 0, 32'h0,  0,   0, 0,  0,  9,  32'h0,        32'h99,       0, 1, 32'h200);
        vecs[14] = mk(0, 0, 32'h0,          0,   0, 0, 32'h0,  0,   0, 0,  9,  9,  32'h99,       32'h99,       1, 1, 32'h200);
    end

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Directed vectors straight after reset.
        for (int k = 0; k < 15; k++) begin
            bus.we0 = vecs[k].we0; bus.wa0 = vecs[k].wa0; bus.wd0 = vecs[k].wd0; bus.wclr0 = vecs[k].wclr0;
            bus.we1 = vecs[k].we1; bus.wa1 = vecs[k].wa1; bus.wd1 = vecs[k].wd1; bus.wclr1 = vecs[k].wclr1;
            bus.iss_en = vecs[k].iss; bus.iss_rd = vecs[k].iss_rd;
            bus.ra0 = vecs[k].ra0; bus.ra1 = vecs[k].ra1;
            #1;
            check($sformatf("vec%0d rd0", k),      bus.rd0,      vecs[k].e_rd0);
            check($sformatf("vec%0d rd1", k),      bus.rd1,      vecs[k].e_rd1);
            check($sformatf("vec%0d rbusy0", k),   bus.rbusy0,   vecs[k].e_rb0);
            check($sformatf("vec%0d rbusy1", k),   bus.rbusy1,   vecs[k].e_rb1);
            check($sformatf("vec%0d busy_vec", k), bus.busy_vec, vecs[k].e_busy);
            tick();
        end

        // Reset while r4 is busy and holds 0x55; a write during reset is dropped.
        idle();
        bus.iss_en = 1; bus.iss_rd = 5'd4;
        tick();
        idle();
        #1;
        check("pre-reset busy_vec[4]", bus.busy_vec[4], 1'b1);
        rst = 1'b1;
        bus.we0 = 1; bus.wa0 = 5'd4; bus.wd0 = 32'hAAAA_AAAA;
        bus.iss_en = 1; bus.iss_rd = 5'd5;
        tick();
        rst = 1'b0;
        idle();
        bus.ra0 = 5'd4; bus.ra1 = 5'd9;
        #1;
        check("post-reset busy_vec", bus.busy_vec, 32'h0);
        check("post-reset rd0 r4",   bus.rd0,      RESET_VAL);
        check("post-reset rd1 r9",   bus.rd1,      RESET_VAL);
        check("post-reset rbusy0",   bus.rbusy0,   1'b0);

        // Randomized traffic on a narrow index range to force collisions.
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            bus.we0    = $urandom_range(0, 1);
            bus.wa0    = 5'($urandom_range(0, 7));
            bus.wd0    = $urandom;
            bus.wclr0  = $urandom_range(0, 1);
            bus.we1    = $urandom_range(0, 1);
            bus.wa1    = 5'($urandom_range(0, 7));
            bus.wd1    = $urandom;
            bus.wclr1  = $urandom_range(0, 1);
            bus.iss_en = $urandom_range(0, 1);
            bus.iss_rd = 5'($urandom_range(0, 7));
            bus.ra0    = 5'($urandom_range(0, 7));
            bus.ra1    = 5'($urandom_range(0, 7));
            #1;
            check($sformatf("rand%0d rd0", n),      bus.rd0,      m_after(int'(bus.ra0)));
            check($sformatf("rand%0d rd1", n),      bus.rd1,      m_after(int'(bus.ra1)));
            check($sformatf("rand%0d rbusy0", n),   bus.rbusy0,
                  m_busy[bus.ra0] && !m_retiring(int'(bus.ra0)));
            check($sformatf("rand%0d rbusy1", n),   bus.rbusy1,
                  m_busy[bus.ra1] && !m_retiring(int'(bus.ra1)));
            check($sformatf("rand%0d busy_vec", n), bus.busy_vec, m_busy);
            tick();
        end

        rst = 1'b0;
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_mp_sb
